// File: rtl/run_monitor_pkg.sv
// Shared types and default constants for the run monitor.
package run_monitor_pkg;

    // Monitor FSM state; the encoding is visible on o_state.
    typedef enum logic [1:0] {
        StHold    = 2'd0,
        StRun     = 2'd1,
        StHalted  = 2'd2,
        StTimeout = 2'd3
    } state_e;

    localparam int unsigned DefPcW       = 32;
    localparam int unsigned DefCntW      = 32;
    localparam int unsigned DefRstHold   = 4;
    localparam int unsigned DefHaltCyc   = 8;
    localparam int unsigned DefTimeoutCyc = 5000;

    // Both terminal states report done.
    function automatic logic is_terminal(state_e s);
        return (s == StHalted) || (s == StTimeout);
    endfunction

endpackage

// File: rtl/run_monitor_if.sv
// Core trace bus observed by the run monitor: debug PC, retire strobe and result.
interface run_monitor_if #(
    parameter int unsigned PC_W = run_monitor_pkg::DefPcW
);
    logic [PC_W-1:0] pc;
    logic            insn_vld;
    logic [31:0]     result;

    // Core side drives the trace.
    modport master (output pc, output insn_vld, output result);
    // Monitor side only observes it.
    modport slave (input pc, input insn_vld, input result);

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    // Count when enabled, holding at the maximum value.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != {WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/run_monitor.sv
// Run monitor: stretches the core reset, counts run cycles and retires, and stops
// on a PC self-loop (halt) or after a fixed cycle budget (timeout).
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int unsigned PC_W        = DefPcW,
    parameter int unsigned CNT_W       = DefCntW,
    parameter int unsigned RST_HOLD    = DefRstHold,
    parameter int unsigned HALT_CYC    = DefHaltCyc,
    parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
    input  logic             i_clk,
    input  logic             i_reset,
    run_monitor_if.slave     i_trace,
    output logic             o_core_rst,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_retired_cnt,
    output logic [PC_W-1:0]  o_last_pc,
    output logic [31:0]      o_result,
    output logic             o_done,
    output logic             o_halt,
    output logic             o_timeout
);

    localparam int unsigned HoldW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int unsigned RepW  = $clog2(HALT_CYC);
    // Compare the cycle count at a width that can hold TIMEOUT_CYC-1 without truncation.
    localparam int unsigned CmpW  = (CNT_W > 32) ? CNT_W : 32;

    state_e           r_state, w_state_d;
    logic [HoldW-1:0] r_hold_cnt;
    logic [RepW-1:0]  r_rep_cnt, w_rep_d;
    logic             r_seen;
    logic [PC_W-1:0]  r_last_pc;
    logic [31:0]      r_result;
    logic             r_core_rst, r_done, r_halt, r_timeout;
    logic             w_retire, w_halt_hit, w_timeout_hit, w_cyc_en, w_clr;
    logic [CNT_W-1:0] w_cycle_cnt, w_retired_cnt;

    // Retire decode, repeat-count update and termination conditions.
    always_comb begin
        w_retire = (r_state == StRun) && i_trace.insn_vld;
        w_rep_d  = r_rep_cnt;
        if (w_retire) begin
            // r_seen keeps the first retire (even at PC 0) from matching the reset PC.
            if (r_seen && (i_trace.pc == r_last_pc)) begin
                w_rep_d = r_rep_cnt + RepW'(1);
            end else begin
                w_rep_d = '0;
            end
        end
        w_halt_hit    = w_retire && (w_rep_d == RepW'(HALT_CYC - 1));
        w_timeout_hit = (r_state == StRun) &&
                        (CmpW'(w_cycle_cnt) == CmpW'(TIMEOUT_CYC - 1));
    end

    // Next-state logic; halt takes priority over timeout.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StHold: begin
                if (r_hold_cnt == HoldW'(RST_HOLD - 1)) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                if (w_halt_hit) begin
                    w_state_d = StHalted;
                end else if (w_timeout_hit) begin
                    w_state_d = StTimeout;
                end
            end
            default: w_state_d = r_state;
        endcase
    end

    // State register and reset-stretch counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StHold;
            r_hold_cnt <= '0;
        end else begin
            r_state <= w_state_d;
            if (r_state == StHold) begin
                r_hold_cnt <= r_hold_cnt + HoldW'(1);
            end
        end
    end

    // Retire tracking and result capture; nothing moves outside RUN.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_seen    <= 1'b0;
            r_rep_cnt <= '0;
            r_last_pc <= '0;
            r_result  <= '0;
        end else begin
            if (w_retire) begin
                r_seen    <= 1'b1;
                r_rep_cnt <= w_rep_d;
                r_last_pc <= i_trace.pc;
            end
            if (w_halt_hit) begin
                r_result <= i_trace.result;
            end
        end
    end

    // Registered status flags, aligned with the state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_halt     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_core_rst <= (w_state_d == StHold);
            r_done     <= is_terminal(w_state_d);
            r_halt     <= (w_state_d == StHalted);
            r_timeout  <= (w_state_d == StTimeout);
        end
    end

    // The cycle count stops on the edge that leaves RUN, so it reports the last run cycle.
    assign w_cyc_en = (r_state == StRun) && (w_state_d == StRun);
    assign w_clr    = (r_state == StHold);

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_cycle_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_clr),
        .i_en    (w_cyc_en),
        .o_cnt   (w_cycle_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_retired_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_clr),
        .i_en    (w_retire),
        .o_cnt   (w_retired_cnt)
    );

    assign o_core_rst    = r_core_rst;
    assign o_state       = r_state;
    assign o_cycle_cnt   = w_cycle_cnt;
    assign o_retired_cnt = w_retired_cnt;
    assign o_last_pc     = r_last_pc;
    assign o_result      = r_result;
    assign o_done        = r_done;
    assign o_halt        = r_halt;
    assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_run_monitor.sv
// Bench for run_monitor: two instances (32-bit and 4-bit counters) share one trace bus and
// are compared every cycle against a streak-based behavioural model.
module tb_run_monitor;
    import run_monitor_pkg::*;

    localparam int unsigned RstHold    = 4;
    localparam int unsigned HaltCyc    = 4;
    localparam int unsigned TimeoutCyc = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic started = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    run_monitor_if #(.PC_W(32)) u_if ();

    logic        a_core_rst, a_done, a_halt, a_timeout;
    logic [1:0]  a_state;
    logic [31:0] a_cyc, a_ret, a_pc, a_res;
    logic        b_core_rst, b_done, b_halt, b_timeout;
    logic [1:0]  b_state;
    logic [3:0]  b_cyc, b_ret;
    logic [31:0] b_pc, b_res;

    run_monitor #(
        .PC_W(32), .CNT_W(32), .RST_HOLD(RstHold), .HALT_CYC(HaltCyc),
        .TIMEOUT_CYC(TimeoutCyc)
    ) u_dut_a (
        .i_clk(clk), .i_reset(rst), .i_trace(u_if), .o_core_rst(a_core_rst),
        .o_state(a_state), .o_cycle_cnt(a_cyc), .o_retired_cnt(a_ret), .o_last_pc(a_pc),
        .o_result(a_res), .o_done(a_done), .o_halt(a_halt), .o_timeout(a_timeout)
    );

    run_monitor #(
        .PC_W(32), .CNT_W(4), .RST_HOLD(RstHold), .HALT_CYC(HaltCyc),
        .TIMEOUT_CYC(TimeoutCyc)
    ) u_dut_b (
        .i_clk(clk), .i_reset(rst), .i_trace(u_if), .o_core_rst(b_core_rst),
        .o_state(b_state), .o_cycle_cnt(b_cyc), .o_retired_cnt(b_ret), .o_last_pc(b_pc),
        .o_result(b_res), .o_done(b_done), .o_halt(b_halt), .o_timeout(b_timeout)
    );

    // Model: 0=hold 1=run 2=halted 3=timeout; streak = trailing run of equal retired PCs.
    int              m_st[2];
    int              m_rel[2];
    int              m_streak[2];
    longint unsigned m_cyc[2], m_ret[2], m_max[2];
    logic [31:0]     m_pc[2], m_res[2];

    task automatic model_step(input int m);
        bit halt;
        if (rst) begin
            m_st[m] = 0; m_rel[m] = 0; m_streak[m] = 0;
            m_cyc[m] = 0; m_ret[m] = 0; m_pc[m] = '0; m_res[m] = '0;
        end else if (m_st[m] == 0) begin
            m_rel[m]++;
            if (m_rel[m] == int'(RstHold)) m_st[m] = 1;
        end else if (m_st[m] == 1) begin
            halt = 1'b0;
            if (u_if.insn_vld) begin
                if (m_streak[m] > 0 && u_if.pc == m_pc[m]) m_streak[m]++;
                else m_streak[m] = 1;
                m_pc[m] = u_if.pc;
                if (m_ret[m] < m_max[m]) m_ret[m]++;
                halt = (m_streak[m] >= int'(HaltCyc));
            end
            if (halt) begin
                m_st[m]  = 2;
                m_res[m] = u_if.result;
            end else if (m_cyc[m] == longint'(TimeoutCyc - 1)) begin
                m_st[m] = 3;
            end else if (m_cyc[m] < m_max[m]) begin
                m_cyc[m]++;
            end
        end
    endtask

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) model_step(m);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input int m, input string p, input logic [1:0] st, input logic cr,
                           input logic [63:0] cyc, input logic [63:0] ret,
                           input logic [31:0] pc, input logic [31:0] res,
                           input logic dn, input logic hl, input logic to);
        check({p, ".state"}, 64'(st), 64'(m_st[m]));
        check({p, ".core_rst"}, 64'(cr), 64'(m_st[m] == 0));
        check({p, ".cycle_cnt"}, cyc, m_cyc[m]);
        check({p, ".retired_cnt"}, ret, m_ret[m]);
        check({p, ".last_pc"}, 64'(pc), 64'(m_pc[m]));
        check({p, ".result"}, 64'(res), 64'(m_res[m]));
        check({p, ".done"}, 64'(dn), 64'(m_st[m] >= 2));
        check({p, ".halt"}, 64'(hl), 64'(m_st[m] == 2));
        check({p, ".timeout"}, 64'(to), 64'(m_st[m] == 3));
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            cmp_dut(0, "A", a_state, a_core_rst, 64'(a_cyc), 64'(a_ret), a_pc, a_res,
                    a_done, a_halt, a_timeout);
            cmp_dut(1, "B", b_state, b_core_rst, 64'(b_cyc), 64'(b_ret), b_pc, b_res,
                    b_done, b_halt, b_timeout);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic vld, input logic [31:0] pc, input logic [31:0] res);
        u_if.insn_vld = vld;
        u_if.pc       = pc;
        u_if.result   = res;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0);
        tick();
        tick();
        rst = 1'b0;
        repeat (RstHold) tick();
    endtask

    // Release reset and pin the stretch: core_rst high for 4 samples, then RUN.
    task automatic release_checked(input string p);
        rst = 1'b0;
        check({p, ".stretch0"}, 64'(a_core_rst), 64'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check({p, ".stretch"}, 64'(a_core_rst), 64'd1);
        end
        tick();
        check({p, ".stretch_end"}, 64'(a_core_rst), 64'd0);
        check({p, ".run_state"}, 64'(a_state), 64'd1);
    endtask

    logic [31:0] seq_a [7];
    logic [31:0] pc_r;
    int          len;

    initial begin
        m_max[0] = 64'hFFFF_FFFF;
        m_max[1] = 64'd15;
        seq_a = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'hC, 32'hC};
        rst = 1'b1;
        drive(1'b0, '0, '0);
        tick();
        started = 1'b1;
        tick();
        check("rst.state", 64'(a_state), 64'd0);
        check("rst.core_rst", 64'(a_core_rst), 64'd1);
        check("rst.done", 64'(a_done), 64'd0);
        release_checked("rel1");

        // Directed halt on the fourth retire of 0xC.
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, seq_a[i], 32'h55);
            tick();
        end
        drive(1'b0, '0, '0);
        check("dirA.state", 64'(a_state), 64'd2);
        check("dirA.result", 64'(a_res), 64'h55);
        check("dirA.retired", 64'(a_ret), 64'd7);
        check("dirA.last_pc", 64'(a_pc), 64'hC);
        check("dirA.halt", 64'(a_halt), 64'd1);

        // PC 0 from the first retire: the first retire is not a repeat.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0, 32'h11);
            tick();
        end
        check("pc0.no_halt_3rd", 64'(a_state), 64'd1);
        drive(1'b1, 32'h0, 32'hA5);
        tick();
        check("pc0.halt_4th", 64'(a_state), 64'd2);
        check("pc0.result", 64'(a_res), 64'hA5);

        // Timeout with distinct PCs; the 4-bit instance saturates instead.
        do_reset();
        pc_r = 32'h1000;
        for (int i = 0; i < 100; i++) begin
            drive(($urandom_range(0, 1) != 0), pc_r, $urandom());
            pc_r += 32'h4;
            tick();
        end
        check("to.state", 64'(a_state), 64'd3);
        check("to.cycle", 64'(a_cyc), 64'd99);
        check("to.halt", 64'(a_halt), 64'd0);
        check("to.timeout", 64'(a_timeout), 64'd1);
        check("sat.state", 64'(b_state), 64'd1);
        check("sat.cycle", 64'(b_cyc), 64'd15);
        repeat (5) tick();
        check("to.frozen", 64'(a_cyc), 64'd99);

        // Halt completing on run cycle 99 beats the simultaneous timeout.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, (i < 96) ? (32'h100 + 32'(i) * 4) : 32'h40, 32'h1000 + 32'(i));
            tick();
        end
        drive(1'b0, '0, '0);
        check("tie.state", 64'(a_state), 64'd2);
        check("tie.timeout", 64'(a_timeout), 64'd0);
        check("tie.result", 64'(a_res), 64'h1063);

        // Reset pulse in HALTED, then mid-RUN.
        rst = 1'b1;
        tick();
        check("rstH.state", 64'(a_state), 64'd0);
        check("rstH.retired", 64'(a_ret), 64'd0);
        check("rstH.result", 64'(a_res), 64'd0);
        release_checked("rel2");
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(i) * 4, $urandom());
            tick();
        end
        rst = 1'b1;
        tick();
        check("rstR.state", 64'(a_state), 64'd0);
        check("rstR.cycle", 64'(a_cyc), 64'd0);
        release_checked("rel3");

        // Randomized episodes with a small PC set and occasional reset pulses.
        pc_r = '0;
        for (int ep = 0; ep < 20; ep++) begin
            rst = 1'b1;
            repeat ($urandom_range(1, 3)) tick();
            rst = 1'b0;
            len = int'($urandom_range(20, 160));
            for (int c = 0; c < len; c++) begin
                rst = ($urandom_range(0, 63) == 0);
                if ($urandom_range(0, 1) == 0) pc_r = {28'd0, 2'($urandom_range(0, 3)), 2'b00};
                drive(($urandom_range(0, 3) != 0), pc_r, $urandom());
                tick();
            end
        end

        rst = 1'b0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
